fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined CPU; successor to the fixed adder + mux + programCounter + instruction-memory IF stage.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses of variable latency and buffers (pc, instruction) pairs in a DEPTH-entry FIFO feeding the IF/ID buffer.
- Adds redirect (branch) flush with discard of stale in-flight responses, a halted state, and decode back-pressure.

Parameters:
DATA_WIDTH, 16, instruction width
ADDR_WIDTH, 16, PC/address width
DEPTH, 4, FIFO entries; power of two, >= 2; also the cap on (queued + in-flight)
PC_STEP, 2, sequential PC increment
RESET_PC, 0, fetch address after reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
redirect  in  1  branch taken; flush and restart at redirectPc
redirectPc  in  ADDR_WIDTH  new fetch address
halt  in  1  one-cycle pulse from decode; stop fetching
imReqValid  out  1  fetch request valid
imReqAddr  out  ADDR_WIDTH  fetch address
imReqReady  in  1  memory accepts request
imRespValid  in  1  response valid (in order, >= 1 cycle after acceptance)
imRespData  in  DATA_WIDTH  instruction word
outValid  out  1  FIFO head valid
outPc  out  ADDR_WIDTH  PC of head instruction
outInstr  out  DATA_WIDTH  head instruction
outReady  in  1  IF/ID consumes head (low = stall)
halted  out  1  state is HALTED
level  out  clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Clock is `clock`. Reset is synchronous and active-high.
- Reset, and the cycle after reset: fetchPc=RESET_PC, FIFO empty (level=0, outValid=0), inflight=0, dropCount=0, state=RUN, halted=0. outPc and outInstr are 0 while empty.
- States: RUN and HALTED.
  - RUN -> HALTED when halt=1 and redirect=0.
  - HALTED -> RUN only on redirect or reset.
- Request: imReqValid = (state==RUN) && !redirect && !halt && (level + inflight < DEPTH). This is combinational.
- imReqAddr = fetchPc.
- Request accepted when imReqValid && imReqReady. On acceptance: fetchPc += PC_STEP, modulo 2^ADDR_WIDTH (wraps), and inflight += 1.
- A PC FIFO of depth DEPTH holds issued addresses, so each response is paired with its request PC.
- Response with dropCount>0: discarded, dropCount -= 1, PC-FIFO entry popped.
- Response with dropCount==0: (PC-FIFO head, imRespData) is pushed into the output FIFO; inflight -= 1.
- Output FIFO is first-word fall-through: outValid = (level>0), and the head appears the cycle after the push. Zero-latency bypass is not allowed.
- Pop when outValid && outReady.
  - Push and pop in the same cycle leaves level unchanged.
  - The credit rule guarantees a push never finds the FIFO full. Overflow is an assertion failure in the bench.
- Redirect (highest priority, same cycle overrides everything):
  - Output FIFO is cleared. level=0 and outValid=0 the next cycle. Any pop that cycle is ignored.
  - fetchPc=redirectPc. State goes to RUN. No request is issued in the redirect cycle.
  - dropCount becomes dropCount + inflight, where inflight excludes a response arriving this cycle. That response is itself discarded. inflight is set to 0.
  - The first request at redirectPc is issued in the following cycle.
- Halt: no new requests. In-flight responses still land in the FIFO, and the FIFO drains normally. halted=1 from the cycle after the halt pulse.
- Halt and redirect in the same cycle: redirect wins and state stays RUN.
- Reset mid-operation clears all state. Responses to pre-reset requests are the memory's responsibility: memory is reset together with this block, so no response arrives after reset.
- Pointer arithmetic wraps modulo DEPTH. Counters saturate never; the credit limit bounds them to <= DEPTH.

Test Plan:
- Reset, memory with 1-cycle latency, imReqReady=1, outReady=1, memory returns word = addr ^ 16'hA5A5 -> requests 0x0000, 0x0002, 0x0004...; outPc/outInstr = 0x0000/0xA5A5, 0x0002/0xA5A7 on consecutive cycles; first outValid 2 cycles after the first request.
- outReady=0 for 10 cycles -> exactly 4 requests (DEPTH) accepted; level=4; imReqValid=0. Releasing outReady resumes at 0x0008 with no lost or duplicated PC.
- Memory latency 3, redirect to 0x0100 while 2 requests are in flight -> both stale responses discarded; first outPc after redirect is 0x0100; level=0 the cycle after redirect.
- halt pulse with 2 queued and 1 in flight -> halted=1 next cycle; no further requests; 3 instructions delivered then outValid=0. Later redirect to 0x0040 -> halted=0 and fetch resumes at 0x0040.
- Redirect coinciding with a response and a pop -> response dropped, pop ignored, level=0, no underflow/overflow assertions. fetchPc=0xFFFE sequential fetch -> next address 0x0000.
- Assert reset for 1 cycle mid-stream with level=3 -> next cycle level=0, outValid=0, imReqAddr=RESET_PC, halted=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses to instruction
// memory, pairs in-order responses with their request PCs, and buffers
// (pc, instruction) pairs in a first-word-fall-through FIFO for decode.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high; valid never depends on ready on the same channel.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter int                    PC_STEP    = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirectPc,
    input  logic                         halt,
    output logic                         imReqValid,
    output logic [ADDR_WIDTH-1:0]        imReqAddr,
    input  logic                         imReqReady,
    input  logic                         imRespValid,
    input  logic [DATA_WIDTH-1:0]        imRespData,
    output logic                         outValid,
    output logic [ADDR_WIDTH-1:0]        outPc,
    output logic [DATA_WIDTH-1:0]        outInstr,
    input  logic                         outReady,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW     = $clog2(DEPTH + 1);
    localparam int LW1    = LW + 1;
    localparam int OW     = $clog2(DEPTH);
    // Stale responses after a redirect still hold PC entries while new
    // requests are issued, so the PC FIFO is twice the output depth.
    localparam int PDEPTH = 2 * DEPTH;
    localparam int PW     = $clog2(PDEPTH);
    localparam int DW     = $clog2(PDEPTH + 1);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [LW-1:0]         inflight;
    logic [DW-1:0]         drop_count;
    logic [LW-1:0]         count;
    logic [OW-1:0]         out_wr;
    logic [OW-1:0]         out_rd;
    logic [PW-1:0]         pc_wr;
    logic [PW-1:0]         pc_rd;

    logic [ADDR_WIDTH-1:0] pc_mem        [PDEPTH];
    logic [ADDR_WIDTH-1:0] out_pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] out_instr_mem [DEPTH];

    logic [LW1-1:0] credit_sum;
    logic           req_fire;
    logic           resp_stale;
    logic           resp_live;
    logic           resp_keep;
    logic           pop;

    // Request credit, response classification and output view of the FIFO head.
    always_comb begin
        credit_sum = LW1'(count) + LW1'(inflight);
        imReqValid = (state == ST_RUN) && !redirect && !halt && (credit_sum < LW1'(DEPTH));
        imReqAddr  = fetch_pc;
        req_fire   = imReqValid && imReqReady;
        resp_stale = (drop_count != '0);
        resp_live  = imRespValid && !resp_stale;
        resp_keep  = resp_live && !redirect;
        outValid   = (count != '0);
        pop        = outValid && outReady && !redirect;
        outPc      = outValid ? out_pc_mem[out_rd] : '0;
        outInstr   = outValid ? out_instr_mem[out_rd] : '0;
        halted     = (state == ST_HALTED);
        level      = count;
    end

    // RUN/HALTED state: redirect restarts fetch and beats a same-cycle halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (redirect) begin
            state <= ST_RUN;
        end else if (halt) begin
            state <= ST_HALTED;
        end
    end

    // Fetch address: jump on redirect, advance by PC_STEP on each accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirectPc;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    // PC FIFO pointers: push per accepted request, pop per response (kept or dropped).
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_wr <= '0;
            pc_rd <= '0;
        end else begin
            if (req_fire) begin
                pc_wr <= pc_wr + PW'(1);
            end
            if (imRespValid) begin
                pc_rd <= pc_rd + PW'(1);
            end
        end
    end

    // PC FIFO storage.
    always_ff @(posedge clock) begin
        if (req_fire) begin
            pc_mem[pc_wr] <= fetch_pc;
        end
    end

    // Outstanding-request bookkeeping; a redirect turns every live request stale.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight   <= '0;
            drop_count <= '0;
        end else if (redirect) begin
            inflight   <= '0;
            drop_count <= drop_count + DW'(inflight) - DW'(imRespValid);
        end else begin
            inflight <= inflight + LW'(req_fire) - LW'(resp_live);
            if (imRespValid && resp_stale) begin
                drop_count <= drop_count - DW'(1);
            end
        end
    end

    // Output FIFO pointers and occupancy; redirect empties it and ignores any pop.
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            out_wr <= '0;
            out_rd <= '0;
            count  <= '0;
        end else begin
            if (resp_keep) begin
                out_wr <= out_wr + OW'(1);
            end
            if (pop) begin
                out_rd <= out_rd + OW'(1);
            end
            count <= count + LW'(resp_keep) - LW'(pop);
        end
    end

    // Output FIFO storage: response paired with the PC it was fetched from.
    always_ff @(posedge clock) begin
        if (resp_keep) begin
            out_pc_mem[out_wr]    <= pc_mem[pc_rd];
            out_instr_mem[out_wr] <= imRespData;
        end
    end

endmodule
